// File: rtl/ff_pkg.sv
// ff_pkg: Q16.16 constants, saturation helpers and FSM state encoding shared by the
// Forward-Forward layer blocks.
package ff_pkg;
    localparam logic signed [31:0] ONE  = 32'sh0001_0000;
    localparam logic signed [31:0] QMAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] QMIN = 32'sh8000_0000;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_STREAM = 3'd1;
    localparam state_t S_DRAIN  = 3'd2;
    localparam state_t S_WRITE  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        return (v > 64'sh0000_0000_7FFF_FFFF) ? QMAX :
               (v < 64'shFFFF_FFFF_8000_0000) ? QMIN : $signed(v[31:0]);
    endfunction

    function automatic logic signed [31:0] q_mul(input logic signed [31:0] a, input logic signed [31:0] b, input int frac);
        logic signed [63:0] p;
        p = a * b;
        return sat32(p >>> frac);
    endfunction
endpackage

// File: rtl/ff_layer_forward_if.sv
// ff_layer_forward_if: weight BRAM port A read bus plus activation-buffer write bus.
interface ff_layer_forward_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WADDR_W    = 18,
    parameter int AADDR_W    = 8
);
    logic [WADDR_W-1:0]    weight_addr_a;
    logic                  weight_en_a;
    logic [DATA_WIDTH-1:0] weight_rdata_a;
    logic                  act_we;
    logic [AADDR_W-1:0]    act_addr;
    logic [DATA_WIDTH-1:0] act_wdata;

    modport master (
        output weight_addr_a, weight_en_a, act_we, act_addr, act_wdata,
        input  weight_rdata_a
    );
    modport slave (
        input  weight_addr_a, weight_en_a, act_we, act_addr, act_wdata,
        output weight_rdata_a
    );
endinterface

// File: rtl/ff_mac_unit.sv
// ff_mac_unit: read-aligned multiply-accumulate with 64-bit saturation and a
// finished ReLU(acc >>> FRAC_BITS) output.
module ff_mac_unit
    import ff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT_SIZE = 784,
    parameter int FRAC_BITS  = 16,
    parameter int XW         = $clog2(INPUT_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 en,
    input  logic [XW-1:0]                        j,
    input  logic [DATA_WIDTH-1:0]                rdata,
    input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0]                y
);
    logic               valid_q, valid_d;
    logic [XW-1:0]      j_q, j_d;
    logic signed [63:0] acc_q, acc_d, prod, sum;
    logic signed [31:0] s;
    logic               ovf;

    // valid/j travel one cycle behind the read so they line up with rdata
    always_comb begin
        valid_d = en;
        j_d     = j;
        prod    = $signed(rdata) * $signed(x[j_q]);
        sum     = acc_q + prod;
        ovf     = (acc_q[63] == prod[63]) && (sum[63] != acc_q[63]);
        acc_d   = clr ? '0 : !valid_q ? acc_q :
                  ovf ? (acc_q[63] ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF) : sum;
        s       = sat32(acc_q >>> FRAC_BITS);
        y       = s[31] ? '0 : s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: rtl/ff_layer_forward.sv
// ff_layer_forward: forward pass of one Forward-Forward layer; streams weights from
// BRAM port A, writes y_i = ReLU(W x)_i and accumulates goodness G = sum y_i^2.
module ff_layer_forward
    import ff_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int INPUT_SIZE  = 784,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int DEPTH       = NUM_NEURONS * INPUT_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [$clog2(INPUT_SIZE+1)-1:0]       active_input_size,
    input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] input_acts,
    output logic                                  busy,
    output logic                                  done,
    output logic [DATA_WIDTH-1:0]                 goodness_out,
    ff_layer_forward_if.master                    mem
);
    localparam int KW = $clog2(INPUT_SIZE + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int XW = $clog2(INPUT_SIZE);

    state_t          state_q, state_d;
    logic [NW-1:0]   i_q, i_d;
    logic [XW-1:0]   j_q, j_d;
    logic [AW-1:0]   base_q, base_d;
    logic [KW-1:0]   keff_q, keff_d;
    logic [31:0]     g_q, g_d, good_q, good_d, sq, g_sum;
    logic            busy_q, busy_d, done_q, done_d;
    logic            clr, last_j;
    logic [DATA_WIDTH-1:0] y;

    ff_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .INPUT_SIZE(INPUT_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .XW        (XW)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (state_q == S_STREAM),
        .j    (j_q),
        .rdata(mem.weight_rdata_a),
        .x    (input_acts),
        .y    (y)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        base_d  = base_q;
        keff_d  = keff_q;
        g_d     = g_q;
        good_d  = good_q;
        clr     = 1'b0;
        last_j  = KW'(j_q) == keff_q - 1'b1;
        sq      = q_mul($signed(y), $signed(y), FRAC_BITS);
        g_sum   = g_q + sq;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_STREAM;
                keff_d  = (active_input_size == '0 || active_input_size > KW'(INPUT_SIZE)) ?
                          KW'(INPUT_SIZE) : active_input_size;
                i_d     = '0;
                j_d     = '0;
                base_d  = '0;
                g_d     = '0;
                clr     = 1'b1;
            end
            S_STREAM: begin
                state_d = last_j ? S_DRAIN : S_STREAM;
                j_d     = last_j ? '0 : j_q + 1'b1;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                clr = 1'b1;
                // both terms are <= 0x7FFFFFFF, so bit 31 of the sum flags overflow
                g_d = g_sum[31] ? QMAX : g_sum;
                if (i_q == NW'(NUM_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                    i_d     = i_q + 1'b1;
                    base_d  = base_q + AW'(INPUT_SIZE);
                end
            end
            S_DONE: begin
                good_d  = g_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
        done_d = state_q == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            base_q  <= '0;
            keff_q  <= '0;
            g_q     <= '0;
            good_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            base_q  <= base_d;
            keff_q  <= keff_d;
            g_q     <= g_d;
            good_q  <= good_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem.weight_en_a   = state_q == S_STREAM;
    assign mem.weight_addr_a = base_q + AW'(j_q);
    assign mem.act_we        = state_q == S_WRITE;
    assign mem.act_addr      = i_q;
    assign mem.act_wdata     = mem.act_we ? y : '0;
    assign busy              = busy_q;
    assign done              = done_q;
    assign goodness_out      = good_q;
endmodule

// File: tb/tb_ff_layer_forward.sv
// tb_ff_layer_forward: table-driven check of the 2-neuron, 4-input layer against a
// 1-cycle BRAM model, plus reset-abort and start-while-busy sequences.
module tb_ff_layer_forward;
    localparam int N  = 2;
    localparam int IS = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [7:0][31:0] w;
        logic [3:0][31:0] xv;
        logic [2:0]       k;
        logic [31:0]      e0, e1, eg;
        int               ecyc;
        int               keff;
        bit               noisy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [2:0] k_in = '0;
    logic [IS-1:0][DW-1:0] x = '0;
    logic busy, done;
    logic [DW-1:0] goodness;
    logic [31:0] wmem [8];
    logic [2:0]  addr_log [$];
    logic [32:0] wr_log [$];
    int dones = 0;
    int overlaps = 0;
    int checks = 0;
    int failures = 0;
    vec_t vecs [8];

    ff_layer_forward_if #(.DATA_WIDTH(DW), .WADDR_W(3), .AADDR_W(1)) mem_if ();

    ff_layer_forward #(.NUM_NEURONS(N), .INPUT_SIZE(IS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .active_input_size(k_in),
        .input_acts       (x),
        .busy             (busy),
        .done             (done),
        .goodness_out     (goodness),
        .mem              (mem_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_if.weight_en_a) begin
            mem_if.weight_rdata_a <= wmem[mem_if.weight_addr_a];
            addr_log.push_back(mem_if.weight_addr_a);
        end
        if (mem_if.act_we) wr_log.push_back({mem_if.act_addr, mem_if.act_wdata});
        if (done) dones++;
        if (mem_if.weight_en_a && mem_if.act_we) overlaps++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0][31:0] w, input logic [3:0][31:0] xv, input logic [2:0] k,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] eg,
                                input int ecyc, input int keff, input bit noisy);
        vec_t v;
        v.w = w; v.xv = xv; v.k = k; v.e0 = e0; v.e1 = e1; v.eg = eg;
        v.ecyc = ecyc; v.keff = keff; v.noisy = noisy;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) wmem[i] = v.w[i];
        x = v.xv;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cyc, a0, w0, d0;
        bit ok;
        load(v);
        a0 = addr_log.size();
        w0 = wr_log.size();
        d0 = dones;
        @(negedge clk);
        k_in = v.k;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
            start = v.noisy && (cyc == 2 || cyc == 7 || cyc == 12);
        end while (!done && cyc < 200);
        start = 1'b0;
        chk({tag, "_cycles"}, 32'(cyc), 32'(v.ecyc));
        chk({tag, "_goodness"}, goodness, v.eg);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_count"}, 32'(dones - d0), 32'd1);
        chk({tag, "_goodness_held"}, goodness, v.eg);
        chk({tag, "_writes"}, 32'(wr_log.size() - w0), 32'd2);
        if (wr_log.size() - w0 == 2) begin
            chk({tag, "_act0"}, wr_log[w0][31:0], v.e0);
            chk({tag, "_act1"}, wr_log[w0+1][31:0], v.e1);
            chk({tag, "_act_addrs"}, {30'd0, wr_log[w0][32], wr_log[w0+1][32]}, 32'd1);
        end
        ok = (addr_log.size() - a0) == 2 * v.keff;
        for (int n = 0; ok && n < 2 * v.keff; n++)
            ok = addr_log[a0+n] == 3'((n / v.keff) * IS + n % v.keff);
        chk({tag, "_addr_seq"}, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = mk({8{32'h0001_0000}}, {4{32'h0000_8000}}, 3'd4, 32'h0002_0000, 32'h0002_0000, 32'h0008_0000, 13, 4, 1'b0);
        vecs[1] = mk({{4{32'h0000_4000}}, {4{32'hFFFF_0000}}}, {4{32'h0001_0000}}, 3'd4, 32'h0, 32'h0001_0000, 32'h0001_0000, 13, 4, 1'b0);
        vecs[2] = mk({8{32'h0001_0000}}, {4{32'h0000_8000}}, 3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 9, 2, 1'b0);
        vecs[3] = mk({8{32'h0001_0000}}, {4{32'h0000_8000}}, 3'd0, 32'h0002_0000, 32'h0002_0000, 32'h0008_0000, 13, 4, 1'b0);
        vecs[4] = mk({8{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 3'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 13, 4, 1'b0);
        vecs[5] = mk({32'h0008_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0000_8000,
                      32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
                     {32'h0002_0000, 32'h0000_4000, 32'h0000_8000, 32'h0001_0000},
                     3'd3, 32'h0002_C000, 32'h0001_0000, 32'h0008_9000, 11, 3, 1'b0);
        vecs[6] = mk(vecs[5].w, vecs[5].xv, 3'd5, 32'h000A_C000, 32'h0011_0000, 32'h0194_9000, 13, 4, 1'b0);
        vecs[7] = mk({8{32'h0001_0000}}, {4{32'h0000_8000}}, 3'd4, 32'h0002_0000, 32'h0002_0000, 32'h0008_0000, 13, 4, 1'b1);

        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_en", 32'(mem_if.weight_en_a), 32'd0);
        chk("reset_we", 32'(mem_if.act_we), 32'd0);
        chk("reset_addr", 32'(mem_if.weight_addr_a), 32'd0);
        chk("reset_goodness", goodness, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

        begin
            int w0;
            load(vecs[0]);
            @(negedge clk);
            k_in = 3'd4;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (7) @(posedge clk);
            #1;
            chk("abort_pre_addr", 32'(mem_if.weight_addr_a), 32'd5);
            w0 = wr_log.size();
            rst_n = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_en", 32'(mem_if.weight_en_a), 32'd0);
            chk("abort_addr", 32'(mem_if.weight_addr_a), 32'd0);
            chk("abort_wdata", mem_if.act_wdata, 32'd0);
            chk("abort_goodness", goodness, 32'd0);
            @(posedge clk);
            #1;
            chk("abort_we", 32'(mem_if.act_we), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_no_write", 32'(wr_log.size() - w0), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1 chk("abort_idle_en", 32'(mem_if.weight_en_a), 32'd0);
            run_vec("post_abort", vecs[0]);
        end

        chk("we_en_overlap", 32'(overlaps), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
